// File: rtl/button_event_fifo.sv
// Collects debounced key-press pulses, arbitrates lowest index first, and queues
// button codes in a first-word-fall-through FIFO with sticky overflow and IRQ.
module button_event_fifo #(
  parameter int NUM_BTN = 4,
  parameter int DEPTH   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_BTN-1:0] i_btn_pulse,
  input  logic               i_rd,
  input  logic               i_clr_ovf,
  output logic [2:0]         o_code,
  output logic               o_empty,
  output logic               o_full,
  output logic [3:0]         o_count,
  output logic               o_irq,
  output logic               o_ovf
);

  localparam int              PW      = $clog2(DEPTH);
  localparam logic [3:0]      DEPTH_C = 4'(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);

  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] grant;
  logic [NUM_BTN-1:0] drained;
  logic [NUM_BTN-1:0] pend_next;
  logic [2:0]         sel_code;
  logic               any_pend;
  logic               push;
  logic               pop;
  logic               lost;

  logic [2:0]         mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [3:0]         count;
  logic               irq;
  logic               ovf;

  always_comb begin
    grant    = '0;
    sel_code = '0;
    any_pend = 1'b0;
    for (int unsigned k = 0; k < NUM_BTN; k++) begin
      if (pend[k] && !any_pend) begin
        any_pend = 1'b1;
        grant[k] = 1'b1;
        sel_code = 3'(k);
      end
    end
  end

  // A full FIFO still accepts a push when the same edge pops the head.
  assign pop       = i_rd && (count != '0);
  assign push      = any_pend && ((count < DEPTH_C) || (i_rd && (count == DEPTH_C)));
  assign drained   = push ? grant : '0;
  assign lost      = |(i_btn_pulse & pend & ~drained);
  assign pend_next = (pend & ~drained) | i_btn_pulse;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      irq    <= 1'b0;
      ovf    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      pend <= pend_next;
      if (push) begin
        mem[wr_ptr] <= sel_code;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      // A pop cannot happen while empty, so any push from empty makes it non-empty.
      irq <= push && (count == '0);
      if (lost) begin
        ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  assign o_empty = (count == '0);
  assign o_full  = (count == DEPTH_C);
  assign o_count = count;
  assign o_code  = o_empty ? 3'd0 : mem[rd_ptr];
  assign o_irq   = irq;
  assign o_ovf   = ovf;

endmodule

// File: tb/tb_button_event_fifo.sv
// Self-checking bench for button_event_fifo: a queue of expected codes is filled
// as pulses are driven and drained/compared as the FIFO head is popped.
module tb_button_event_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = '0;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] code;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       irq;
  logic       ovf;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_code;

  button_event_fifo #(.NUM_BTN(4), .DEPTH(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_btn_pulse(btn),
    .i_rd(rd),
    .i_clr_ovf(clr),
    .o_code(code),
    .o_empty(empty),
    .o_full(full),
    .o_count(count),
    .o_irq(irq),
    .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 4'b1111;
    tick();
    tick();
    rst = 1'b0;
    btn = '0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", code); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    tick();
    tick();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_pulse_dropped got=%0d exp=0", count); end
  endtask

  task automatic test_single();
    btn = 4'b0100;
    tick();
    btn = '0;
    exp_q.push_back(3'd2);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_latency_empty got=%0b exp=1", empty); end
    tick();
    checks++; if (code !== exp_q[0]) begin failures++; $display("FAIL single_code got=%0d exp=%0d", code, exp_q[0]); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_empty got=%0b exp=0", empty); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL single_irq_hi got=%0b exp=1", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_lo got=%0b exp=0", irq); end
    tick();
    exp_code = exp_q.pop_front();
    checks++; if (code !== exp_code) begin failures++; $display("FAIL single_head got=%0d exp=%0d", code, exp_code); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_pop_empty got=%0b exp=1", empty); end
    checks++; if (code !== 3'd0) begin failures++; $display("FAIL single_pop_code got=%0d exp=0", code); end
  endtask

  task automatic test_simultaneous();
    btn = 4'b1011;
    tick();
    btn = '0;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd3);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (count !== 4'(i)) begin failures++; $display("FAIL simul_count got=%0d exp=%0d", count, i); end
    end
    rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_code = exp_q.pop_front();
      checks++; if (code !== exp_code) begin failures++; $display("FAIL simul_order got=%0d exp=%0d", code, exp_code); end
      tick();
    end
    rd = 1'b0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL simul_drained got=%0d exp=0", count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL simul_ovf got=%0b exp=0", ovf); end
  endtask

  task automatic test_full_ovf();
    logic [3:0] bv;
    int cyc;
    for (int b = 0; b < 4; b++) begin
      bv = 4'b0001 << b;
      btn = bv;
      tick();
      btn = '0;
      exp_q.push_back(3'(b));
      tick();
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", full); end
    btn = 4'b0010;
    tick();
    btn = '0;
    exp_q.push_back(3'd1);
    tick();
    checks++; if (count !== 4'd4) begin failures++; $display("FAIL held_count got=%0d exp=4", count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL held_ovf got=%0b exp=0", ovf); end
    btn = 4'b0010;
    tick();
    btn = '0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL lost_ovf got=%0b exp=1", ovf); end
    exp_code = exp_q.pop_front();
    checks++; if (code !== exp_code) begin failures++; $display("FAIL full_head got=%0d exp=%0d", code, exp_code); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (count !== 4'd4) begin failures++; $display("FAIL pop_push_count got=%0d exp=4", count); end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      if (!empty) begin
        exp_code = exp_q.pop_front();
        checks++; if (code !== exp_code) begin failures++; $display("FAIL full_drain got=%0d exp=%0d", code, exp_code); end
        rd = 1'b1;
      end else begin
        rd = 1'b0;
      end
      tick();
      cyc++;
    end
    rd = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_drain_timeout left=%0d exp=0", exp_q.size()); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drain_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_empty_pop_clr();
    int cyc;
    rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL epop_count got=%0d exp=0", count); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL epop_irq got=%0b exp=0", irq); end
      checks++; if (code !== 3'd0) begin failures++; $display("FAIL epop_code got=%0d exp=0", code); end
    end
    rd = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL clr_alone got=%0b exp=0", ovf); end
    btn = 4'b0011;
    tick();
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    btn = 4'b0010;
    clr = 1'b1;
    tick();
    btn = '0;
    clr = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL set_wins got=%0b exp=1", ovf); end
    tick();
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL lost_count got=%0d exp=2", count); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL clr_again got=%0b exp=0", ovf); end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      if (!empty) begin
        exp_code = exp_q.pop_front();
        checks++; if (code !== exp_code) begin failures++; $display("FAIL clr_drain got=%0d exp=%0d", code, exp_code); end
        rd = 1'b1;
      end else begin
        rd = 1'b0;
      end
      tick();
      cyc++;
    end
    rd = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL clr_drain_timeout left=%0d exp=0", exp_q.size()); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL clr_drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    logic [3:0] bv;
    int cyc;
    for (int i = 0; i < 12; i++) begin
      if (i >= 2) begin
        exp_code = exp_q.pop_front();
        checks++; if (code !== exp_code) begin failures++; $display("FAIL wrap_code got=%0d exp=%0d", code, exp_code); end
        rd = 1'b1;
      end
      bv = 4'b0001 << (i % 4);
      btn = bv;
      tick();
      exp_q.push_back(3'(i % 4));
      if (i >= 1) begin
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", count); end
        checks++; if (irq !== (i == 1)) begin failures++; $display("FAIL wrap_irq got=%0b exp=%0b", irq, (i == 1)); end
      end
    end
    btn = '0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      if (!empty) begin
        exp_code = exp_q.pop_front();
        checks++; if (code !== exp_code) begin failures++; $display("FAIL wrap_drain got=%0d exp=%0d", code, exp_code); end
        rd = 1'b1;
      end else begin
        rd = 1'b0;
      end
      tick();
      cyc++;
    end
    rd = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_timeout left=%0d exp=0", exp_q.size()); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_reset_mid();
    btn = 4'b1111;
    tick();
    btn = 4'b1000;
    tick();
    btn = '0;
    tick();
    btn = 4'b0001;
    tick();
    btn = '0;
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL mid_count_pre got=%0d exp=3", count); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL mid_ovf_pre got=%0b exp=1", ovf); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_empty got=%0b exp=1", empty); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL mid_ovf got=%0b exp=0", ovf); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (empty !== 1'b1 || count !== 4'd0 || code !== 3'd0) begin
        failures++; $display("FAIL mid_stale empty=%0b count=%0d code=%0d exp=1/0/0", empty, count, code);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_full_ovf();
    test_empty_pop_clr();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
